// File: rtl/ramp_burst_ctrl.sv
// Burst sequencer for the triangle ramp generator: gates the generator enable for
// a fixed number of full 0->PEAK->0 periods, homes the ramp on abort, flags overrange.
module ramp_burst_ctrl #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned DIV_W = 8,
  parameter int unsigned PEAK  = 100
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [DIV_W-1:0] div,
  input  logic [WIDTH-1:0] ramp_data,
  output logic             ramp_enable,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] periods_done,
  output logic             err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOME = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             abt_q, abt_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             err_q, err_d;

  logic             presc_hit_c;
  logic [DIV_W-1:0] presc_nxt_c;
  logic             ramp_zero_c;
  logic             period_end_c;
  logic             over_peak_c;
  logic [CNT_W-1:0] cnt_inc_c;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      abt_q     <= 1'b0;
      presc_q   <= '0;
      div_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      prev_q    <= '0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      abt_q     <= abt_d;
      presc_q   <= presc_d;
      div_q     <= div_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      prev_q    <= prev_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      err_q     <= err_d;
    end
  end

  // Prescaler, period detect (falling back to zero) and overrange helpers
  always_comb begin
    presc_hit_c  = (presc_q == div_q);
    presc_nxt_c  = presc_hit_c ? '0 : presc_q + DIV_W'(1);
    ramp_zero_c  = (ramp_data == '0);
    period_end_c = (prev_q != '0) && ramp_zero_c;
    over_peak_c  = (ramp_data > WIDTH'(PEAK));
    cnt_inc_c    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  end

  always_comb begin
    state_d   = state_q;
    abt_d     = abt_q;
    presc_d   = presc_q;
    div_d     = div_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    prev_d    = ramp_data;
    en_d      = 1'b0;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    err_d     = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          if (burst_len == '0) begin
            done_d = 1'b1;
          end else begin
            len_d   = burst_len;
            div_d   = div;
            cnt_d   = '0;
            err_d   = 1'b0;
            presc_d = '0;
            abt_d   = 1'b0;
            state_d = ramp_zero_c ? ST_RUN : ST_HOME;
          end
        end
      end

      ST_RUN: begin
        if (over_peak_c) err_d = 1'b1;
        presc_d = presc_nxt_c;
        en_d    = presc_hit_c;
        if (period_end_c) cnt_d = cnt_inc_c;
        // Terminal completion takes priority over a coincident abort
        if (period_end_c && (cnt_inc_c == len_q)) begin
          state_d = ST_IDLE;
          en_d    = 1'b0;
          done_d  = 1'b1;
        end else if (abort) begin
          abt_d = 1'b1;
          if (ramp_zero_c) begin
            state_d   = ST_IDLE;
            en_d      = 1'b0;
            aborted_d = 1'b1;
          end else begin
            state_d = ST_HOME;
          end
        end
      end

      ST_HOME: begin
        if (over_peak_c) err_d = 1'b1;
        if (ramp_zero_c) begin
          en_d = 1'b0;
          if (abt_q || abort) begin
            state_d   = ST_IDLE;
            abt_d     = 1'b1;
            aborted_d = 1'b1;
          end else begin
            state_d = ST_RUN;
            presc_d = '0;
          end
        end else begin
          presc_d = presc_nxt_c;
          en_d    = presc_hit_c;
          if (abort) abt_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign ramp_enable  = en_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign aborted      = aborted_q;
  assign periods_done = cnt_q;
  assign err          = err_q;

endmodule

// File: tb/tb_ramp_burst_ctrl.sv
// Directed bench for ramp_burst_ctrl with a behavioural triangle generator
// stepping on enabled falling edges.
module tb_ramp_burst_ctrl;

  localparam int unsigned WIDTH = 7;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned DIV_W = 8;
  localparam int unsigned PEAK  = 100;
  localparam int BUDGET = 5000;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] burst_len = '0;
  logic [DIV_W-1:0] div = '0;
  logic [WIDTH-1:0] ramp_data;
  logic             ramp_enable;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [CNT_W-1:0] periods_done;
  logic             err;

  logic [WIDTH-1:0] gen_val = '0;
  logic             gen_up = 1'b1;
  logic             force_hi = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  ramp_burst_ctrl #(
    .WIDTH(WIDTH), .CNT_W(CNT_W), .DIV_W(DIV_W), .PEAK(PEAK)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .burst_len(burst_len), .div(div), .ramp_data(ramp_data),
    .ramp_enable(ramp_enable), .busy(busy), .done(done), .aborted(aborted),
    .periods_done(periods_done), .err(err)
  );

  always #5 clock = ~clock;

  // Triangle generator model: 0..100..0, one step per enabled falling edge
  always @(negedge clock) begin
    if (ramp_enable) begin
      if (gen_up) begin
        gen_val <= gen_val + 7'd1;
        if (gen_val == 7'd99) gen_up <= 1'b0;
      end else begin
        gen_val <= gen_val - 7'd1;
        if (gen_val == 7'd1) gen_up <= 1'b1;
      end
    end
  end

  assign ramp_data = force_hi ? 7'd101 : gen_val;

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Start a burst at edge 0 and follow it until busy drops or the budget expires
  task automatic run_burst(input int len, input int d, input int abort_at, input int force_at,
                           output int end_edge, output int en_cnt, output int done_cnt,
                           output int abt_cnt, output int first_en, output int peak);
    end_edge = -1; en_cnt = 0; done_cnt = 0; abt_cnt = 0; first_en = -1; peak = 0;
    burst_len = CNT_W'(len);
    div = DIV_W'(d);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_e0", int'(busy), 1);
    check("err_e0", int'(err), 0);
    check("pd_e0", int'(periods_done), 0);
    for (int e = 1; e <= BUDGET; e++) begin
      abort = (e == abort_at);
      force_hi = (e == force_at);
      tick();
      abort = 1'b0;
      force_hi = 1'b0;
      if (ramp_enable) begin
        en_cnt++;
        if (first_en < 0) first_en = e;
      end
      if (busy && int'(gen_val) > peak) peak = int'(gen_val);
      if (done) done_cnt++;
      if (aborted) abt_cnt++;
      if (!busy) begin
        end_edge = e;
        break;
      end
    end
  endtask

  int end_edge, en_cnt, done_cnt, abt_cnt, first_en, peak;

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_en", int'(ramp_enable), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_abt", int'(aborted), 0);
    check("rst_err", int'(err), 0);
    check("rst_pd", int'(periods_done), 0);
    reset = 1'b1;
    tick();

    // One period, continuous stepping
    run_burst(1, 0, -1, -1, end_edge, en_cnt, done_cnt, abt_cnt, first_en, peak);
    check("b1_end", end_edge, 201);
    check("b1_first_en", first_en, 1);
    check("b1_en_cnt", en_cnt, 200);
    check("b1_peak", peak, 100);
    check("b1_done", int'(done), 1);
    check("b1_done_cnt", done_cnt, 1);
    check("b1_en_end", int'(ramp_enable), 0);
    check("b1_pd", int'(periods_done), 1);
    check("b1_ramp", int'(gen_val), 0);
    tick();
    check("b1_done_drop", int'(done), 0);
    check("b1_pd_hold", int'(periods_done), 1);

    // Three periods, step every third cycle
    run_burst(3, 2, -1, -1, end_edge, en_cnt, done_cnt, abt_cnt, first_en, peak);
    check("b3_end", end_edge, 1801);
    check("b3_first_en", first_en, 3);
    check("b3_en_cnt", en_cnt, 600);
    check("b3_pd", int'(periods_done), 3);
    check("b3_done_cnt", done_cnt, 1);
    tick();

    // Abort while rising at 49: home through the peak back to zero
    run_burst(2, 0, 50, -1, end_edge, en_cnt, done_cnt, abt_cnt, first_en, peak);
    check("ab_end", end_edge, 201);
    check("ab_aborted", int'(aborted), 1);
    check("ab_abt_cnt", abt_cnt, 1);
    check("ab_done_cnt", done_cnt, 0);
    check("ab_peak", peak, 100);
    check("ab_ramp", int'(gen_val), 0);
    check("ab_pd", int'(periods_done), 0);
    tick();
    check("ab_abt_drop", int'(aborted), 0);

    // Zero-length burst, then start suppressed by abort
    burst_len = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("z_done", int'(done), 1);
    check("z_busy", int'(busy), 0);
    tick();
    check("z_done_drop", int'(done), 0);
    check("z_en", int'(ramp_enable), 0);
    burst_len = CNT_W'(2);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("sa_busy", int'(busy), 0);
    check("sa_done", int'(done), 0);
    tick();
    check("sa_en", int'(ramp_enable), 0);

    // Reset mid-burst with the generator left at 60 (rising)
    burst_len = CNT_W'(2);
    div = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (gen_val == 7'd60) break;
      tick();
    end
    check("mr_gen60", int'(gen_val), 60);
    #1 reset = 1'b0;
    #1;
    check("mr_en", int'(ramp_enable), 0);
    check("mr_busy", int'(busy), 0);
    check("mr_pd", int'(periods_done), 0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("mr_gen_hold", int'(gen_val), 60);
    // Homing: 140 steps to zero, then a fresh 200-step period
    run_burst(1, 0, -1, -1, end_edge, en_cnt, done_cnt, abt_cnt, first_en, peak);
    check("hm_end", end_edge, 342);
    check("hm_first_en", first_en, 1);
    check("hm_en_cnt", en_cnt, 340);
    check("hm_pd", int'(periods_done), 1);
    check("hm_done_cnt", done_cnt, 1);
    check("hm_ramp", int'(gen_val), 0);
    tick();

    // Overrange sample sets sticky err; next start clears it
    run_burst(1, 0, -1, 100, end_edge, en_cnt, done_cnt, abt_cnt, first_en, peak);
    check("er_end", end_edge, 201);
    check("er_err_done", int'(err), 1);
    tick();
    check("er_err_hold", int'(err), 1);
    run_burst(1, 0, -1, -1, end_edge, en_cnt, done_cnt, abt_cnt, first_en, peak);
    check("er_end2", end_edge, 201);
    check("er_err_clr", int'(err), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ramp_burst_ctrl.md
# ramp_burst_ctrl

Sequencer for the triangle ramp generator: 0 up to 100, back down to 0, stepping on each enabled falling clock edge. It accepts a start command carrying a burst length and a step-rate divider, and gates the generator's enable so it runs exactly that many full triangle periods. It also homes the generator back to 0 on abort and reports completion. It sits between the control register interface and the ramp datapath, owning the generator's enable input.

## Interface
- WIDTH, 7, width of ramp sample bus
- CNT_W, 8, width of burst length / period counter
- DIV_W, 8, width of step-rate divider
- PEAK, 100, largest legal ramp sample; larger values flag an error
- clock  in  1  system clock; all controller state on rising edge
- reset  in  1  asynchronous, active-low
- start  in  1  one-cycle command strobe, sampled in IDLE only
- abort  in  1  level/strobe; stop burst and home ramp to 0
- burst_len  in  CNT_W  number of full periods; latched at start
- div  in  DIV_W  one ramp step every div+1 cycles; latched at start
- ramp_data  in  WIDTH  generator output; changes on falling edge
- ramp_enable  out  1  registered enable to generator
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse, burst completed normally
- aborted  out  1  one-cycle pulse, abort homing completed
- periods_done  out  CNT_W  full periods completed in current/last burst
- err  out  1  sticky, ramp_data > PEAK seen while busy; cleared by start or reset

## Operation
- States: IDLE, HOME, RUN. A flag `abt` records whether HOME was entered via abort.
- IDLE behaviour:
  - start=1, abort=0, burst_len≠0: latch burst_len and div, clear periods_done, err and prescaler.
  - Next state is RUN if ramp_data==0, else HOME with abt=0 (pre-start homing).
  - start with burst_len==0: done pulses next cycle, stays IDLE.
  - abort in IDLE is ignored, except that it suppresses a simultaneous start.
- Prescaler (RUN and HOME): at each edge, if presc==div then presc←0 and ramp_enable←1; else presc←presc+1 and ramp_enable←0. div=0 gives continuous enable.
- Period completion, evaluated in RUN: the prior sample was nonzero and the current ramp_data==0.
  - periods_done increments (saturating at all-ones).
  - If the new count == burst_len: state←IDLE, ramp_enable←0 on the same edge, done←1.
- Abort in RUN: state←HOME, abt=1. If ramp_data==0 on that edge, go straight to IDLE with aborted←1.
- HOME: keep stepping at the prescaled rate until ramp_data==0. On that edge: ramp_enable←0.
  - If abt=1: IDLE and aborted←1.
  - If abt=0: RUN with presc←0.
- Simultaneous terminal completion and abort: completion wins; done pulses, aborted does not.
- err is set on any edge in RUN/HOME where ramp_data>PEAK. It does not change state.

## Timing
- Reset values: state IDLE; ramp_enable, busy, done, aborted, err = 0; periods_done = 0. Reset acts immediately on assertion, mid-burst included.
- start accepted at edge 0 (ramp at 0): busy=1 from edge 0. First ramp_enable=1 at edge div+1, then every div+1 edges.
- The generator steps on the falling edge inside each enabled cycle. The controller samples the new value at the following rising edge, a half-cycle path.
- One period is 200 steps. For burst_len=N, done is asserted at edge 200·N·(div+1)+1; ramp_enable and busy fall on that same edge.
- No extra step is ever issued after the final zero: ramp_enable is deasserted on the edge that observes it.
- done and aborted are high for exactly one cycle. periods_done holds its value in IDLE until the next accepted start.
- start while busy: ignored.

## Test plan
- Reset then start, burst_len=1, div=0 → ramp_enable high edges 1..200; ramp peaks 100; done at edge 201; periods_done=1; ramp_data=0.
- burst_len=3, div=2 → enable every 3rd cycle; done at edge 1801; periods_done=3; exactly 600 enable pulses.
- Abort at edge 50 of a burst_len=2, div=0 run (ramp≈49, rising) → busy stays high while ramp climbs to 100 and returns to 0; aborted pulses one cycle; done never pulses; ramp_data=0.
- Start with burst_len=0 → done pulses one cycle later; ramp_enable never asserts; start+abort in the same cycle → nothing happens.
- Reset asserted mid-burst (ramp=60), then released → all outputs 0 immediately; FSM in IDLE. A following start with the generator left nonzero enters HOME first, then RUN from 0.
- Force ramp_data=101 while busy → err sets and stays set through done; the next start clears it.
